// File: rtl/half_word_serializer_pkg.sv
// rtl/half_word_serializer_pkg.sv - shared constants, state encoding and helpers for the half-word serializer
//
// Purpose: widths, the saturation limit of the compressed-word counter, the FSM
// state type and the zero-extension test used when a word is accepted.
// Ports: none (package).

package half_word_serializer_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  localparam logic [HALF_W-1:0] COMP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_BEAT0 = 2'd1,
    SER_BEAT1 = 2'd2
  } ser_state_e;

  // A word fits in one beat when its upper half is pure zero-extension.
  function automatic logic is_compressible(input logic [WORD_W-1:0] word);
    return (word[WORD_W-1:HALF_W] == '0);
  endfunction

endpackage

// File: rtl/half_word_serializer.sv
// rtl/half_word_serializer.sv - splits 32-bit words into 16-bit beats with optional zero-extension compression
//
// Purpose: accepts a 32-bit word over a valid/ready handshake and emits it as one
// or two 16-bit beats on a fully registered valid/ready output.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   in_valid    in_data holds a word to send
//   in_ready    a word is accepted this cycle when in_valid is also high
//   in_data     32-bit word to serialize
//   out_valid   out_data holds a valid beat
//   out_ready   sink consumes the beat this cycle
//   out_data    current 16-bit beat
//   out_last    current beat is the final beat of its word
//   out_ext     single-beat word; sink zero-extends it to 32 bits
//   comp_count  saturating count of compressed words sent

module half_word_serializer
  import half_word_serializer_pkg::*;
#(
  parameter bit COMPRESS_EN = 1'b1,
  parameter bit LOW_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_data,
  output logic              out_last,
  output logic              out_ext,
  output logic [HALF_W-1:0] comp_count
);

  ser_state_e        state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [HALF_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              ext_q, ext_d;
  logic [HALF_W-1:0] count_q, count_d;

  logic word_accept;
  logic beat_xfer;
  logic compress;

  assign out_valid  = (state_q != SER_IDLE);
  assign out_data   = data_q;
  assign out_last   = last_q;
  assign out_ext    = ext_q;
  assign comp_count = count_q;

  // Accepting on the final beat's transfer lets words stream without a bubble.
  assign in_ready    = (state_q == SER_IDLE) || (out_valid && last_q && out_ready);
  assign word_accept = in_valid && in_ready;
  assign beat_xfer   = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_d   = data_q;
    last_d   = last_q;
    ext_d    = ext_q;
    count_d  = count_q;
    compress = COMPRESS_EN && is_compressible(in_data);

    if (beat_xfer && ext_q && (count_q != COMP_CNT_MAX)) begin
      count_d = count_q + 16'd1;
    end

    case (state_q)
      SER_IDLE: begin
        state_d = SER_IDLE;
      end
      SER_BEAT0: begin
        if (beat_xfer) begin
          if (last_q) begin
            state_d = SER_IDLE;
            last_d  = 1'b0;
            ext_d   = 1'b0;
          end else begin
            state_d = SER_BEAT1;
            data_d  = LOW_FIRST ? hold_q[WORD_W-1:HALF_W] : hold_q[HALF_W-1:0];
            last_d  = 1'b1;
            ext_d   = 1'b0;
          end
        end
      end
      SER_BEAT1: begin
        if (beat_xfer) begin
          state_d = SER_IDLE;
          last_d  = 1'b0;
          ext_d   = 1'b0;
        end
      end
      default: begin
        state_d = SER_IDLE;
        last_d  = 1'b0;
        ext_d   = 1'b0;
      end
    endcase

    // A new word can only be accepted from IDLE or on the last beat's
    // transfer, so loading here safely overrides the transitions above.
    if (word_accept) begin
      state_d = SER_BEAT0;
      hold_d  = in_data;
      last_d  = compress;
      ext_d   = compress;
      if (compress || LOW_FIRST) begin
        data_d = in_data[HALF_W-1:0];
      end else begin
        data_d = in_data[WORD_W-1:HALF_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
      hold_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ext_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ext_q   <= ext_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_half_word_serializer.sv
// tb/tb_half_word_serializer.sv - self-checking bench for half_word_serializer across three parameter sets

module tb_half_word_serializer;

  localparam int N = 3;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic        e;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid   [N];
  logic        in_ready   [N];
  logic [31:0] in_data    [N];
  logic        out_valid  [N];
  logic        out_ready  [N];
  logic [15:0] out_data   [N];
  logic        out_last   [N];
  logic        out_ext    [N];
  logic [15:0] comp_count [N];

  beat_t       expq [N][$];
  logic [31:0] srcq [N][$];
  logic [15:0] cnt  [N];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance 0: compress, low first. 1: compress, high first. 2: no compress, low first.
  for (genvar g = 0; g < N; g++) begin : g_dut
    half_word_serializer #(
      .COMPRESS_EN(g != 2),
      .LOW_FIRST  (g != 1)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .out_ext   (out_ext[g]),
      .comp_count(comp_count[g])
    );
  end

  function automatic bit ce(int k);
    return k != 2;
  endfunction

  function automatic bit lf(int k);
    return k != 1;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Reference: the beat sequence a word must produce on instance k.
  task automatic push_word(int k, logic [31:0] w);
    logic [15:0] lo, hi;
    lo = w[15:0];
    hi = w[31:16];
    if (ce(k) && hi == 16'h0000) begin
      expq[k].push_back(beat_t'{d: lo, l: 1'b1, e: 1'b1});
    end else if (lf(k)) begin
      expq[k].push_back(beat_t'{d: lo, l: 1'b0, e: 1'b0});
      expq[k].push_back(beat_t'{d: hi, l: 1'b1, e: 1'b0});
    end else begin
      expq[k].push_back(beat_t'{d: hi, l: 1'b0, e: 1'b0});
      expq[k].push_back(beat_t'{d: lo, l: 1'b1, e: 1'b0});
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        in_valid[k] = 1'b1;
        in_data[k]  = srcq[k][0];
      end else begin
        in_valid[k] = 1'b0;
        in_data[k]  = $urandom;
      end
    end
  endtask

  // Check all outputs at the falling edge, then advance the model to the
  // handshakes that the next rising edge will perform.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      bit    ev;
      bit    er;
      beat_t h;
      ev = (expq[k].size() != 0);
      h  = ev ? expq[k][0] : '0;
      chk("out_valid", k, out_valid[k], ev);
      if (ev) begin
        chk("out_data", k, out_data[k], h.d);
        chk("out_last", k, out_last[k], h.l);
        chk("out_ext",  k, out_ext[k],  h.e);
      end
      er = !ev || (h.l && out_ready[k]);
      chk("in_ready",   k, in_ready[k],   er);
      chk("comp_count", k, comp_count[k], cnt[k]);
      if (reset) begin
        expq[k].delete();
        cnt[k] = 16'h0000;
      end else begin
        if (ev && out_ready[k]) begin
          void'(expq[k].pop_front());
          if (h.e && cnt[k] != 16'hFFFF) cnt[k] = cnt[k] + 16'd1;
        end
        if (in_valid[k] && er) begin
          push_word(k, in_data[k]);
          void'(srcq[k].pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy();
    for (int k = 0; k < N; k++) begin
      if (expq[k].size() != 0 || srcq[k].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", 0, {31'd0, busy()}, 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {16'h0000, r[15:0]};
      1:       return {16'h0001, r[15:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] pick_dir(int i);
    case (i)
      0:       return 32'h1234ABCD;
      1:       return 32'h00005A5A;
      2:       return 32'h00015A5A;
      3:       return 32'hCAFE0001;
      4:       return 32'h00007777;
      5:       return 32'h00000000;
      default: return 32'h00010000;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      out_ready[k] = 1'b1;
      cnt[k]       = 16'h0000;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_out_valid",  k, out_valid[k],  0);
      chk("rst_out_data",   k, out_data[k],   0);
      chk("rst_out_last",   k, out_last[k],   0);
      chk("rst_out_ext",    k, out_ext[k],    0);
      chk("rst_comp_count", k, comp_count[k], 0);
      chk("rst_in_ready",   k, in_ready[k],   1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive();

    // Directed single words, each drained before the next.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < N; k++) srcq[k].push_back(pick_dir(i));
      drive();
      drain(10);
    end

    // Back-pressure: beat held for 5 cycles while a second word waits.
    for (int k = 0; k < N; k++) begin
      out_ready[k] = 1'b0;
      srcq[k].push_back(32'hDEADBEEF);
      srcq[k].push_back(32'h0BAD0BAD);
    end
    drive();
    repeat (6) step();
    for (int k = 0; k < N; k++) out_ready[k] = 1'b1;
    drain(20);

    // Back-to-back stream.
    for (int k = 0; k < N; k++) begin
      srcq[k].push_back(32'h00000001);
      srcq[k].push_back(32'hFFFF0002);
      srcq[k].push_back(32'h00000003);
    end
    drive();
    drain(20);

    // Reset while the second beat is presented.
    for (int k = 0; k < N; k++) srcq[k].push_back(32'h11112222);
    drive();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("mid_rst_out_valid",  k, out_valid[k],  0);
      chk("mid_rst_out_last",   k, out_last[k],   0);
      chk("mid_rst_comp_count", k, comp_count[k], 0);
      chk("mid_rst_in_ready",   k, in_ready[k],   1);
    end
    @(posedge clk);
    #1;
    drive();

    // Randomized words, gaps and back-pressure.
    repeat (600) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0) srcq[k].push_back(rand_word());
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      drive();
      step();
    end
    for (int k = 0; k < N; k++) out_ready[k] = 1'b1;
    drain(3000);

    // Counter saturation on the low-first compressing instance.
    for (int i = 0; i < 65540; i++) srcq[0].push_back({16'h0000, 16'(i)});
    drive();
    drain(70000);
    @(negedge clk);
    chk("comp_count_saturated", 0, comp_count[0], 32'h0000FFFF);
    chk("comp_count_nocompress", 2, comp_count[2], 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
